// File: rtl/game_pkg.sv
// Shared definitions for the memory-game input path.
//
// Contents:
//   TILE_W                         width of a tile number (four tiles)
//   EASY_LEN, NORMAL_LEN, HARD_LEN sequence lengths for the three difficulties
//   state_t                        state encoding of the player input checker
//   lowest_tile()                  picks the lowest-numbered tile from a press mask
package game_pkg;

    localparam int unsigned TILE_W = 2;

    localparam logic [4:0] EASY_LEN   = 5'd3;
    localparam logic [4:0] NORMAL_LEN = 5'd6;
    localparam logic [4:0] HARD_LEN   = 5'd9;

    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StWaitPress   = 3'd1,
        StCompare     = 3'd2,
        StWaitRelease = 3'd3,
        StPass        = 3'd4,
        StFail        = 3'd5
    } state_t;

    // Several tiles can fall in the same cycle; the lowest index is taken
    // and the rest are dropped.
    function automatic logic [TILE_W-1:0] lowest_tile(input logic [3:0] fall);
        logic [TILE_W-1:0] tile;
        tile = '0;
        if (fall[0]) begin
            tile = 2'd0;
        end else if (fall[1]) begin
            tile = 2'd1;
        end else if (fall[2]) begin
            tile = 2'd2;
        end else if (fall[3]) begin
            tile = 2'd3;
        end
        return tile;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Two-flop synchroniser and falling-edge detector for the four active-low
// tile push-buttons.
//
// Ports:
//   clock_i     rising-edge clock
//   reset_i     synchronous active-high reset; loads every stage with all-ones
//               (all buttons released)
//   enable_i    when low, no edges are reported (and none are remembered)
//   key_i       raw active-low buttons
//   key_sync_o  synchronised button levels
//   key_fall_o  one bit per button, high for one cycle on a 1-to-0 transition
//               of the synchronised level while enable_i is high
module key_edge_detect (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic [3:0] key_i,
    output logic [3:0] key_sync_o,
    output logic [3:0] key_fall_o
);

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] prev_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
            prev_q  <= 4'b1111;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // prev_q always tracks the synchronised level, so an edge that happens
    // while disabled is simply lost rather than reported later.
    always_comb begin
        key_sync_o = sync2_q;
        key_fall_o = enable_i ? (prev_q & ~sync2_q) : 4'b0000;
    end

endmodule

// File: rtl/player_input_checker.sv
// Checks the player's button presses against the stored tile sequence.
//
// After the graphics controller finishes playback (start), the checker waits
// for one press per sequence entry, compares it with the sequence store,
// waits for all buttons to be released, and advances. A mismatch or an
// inactivity timeout ends the round with wrong; a full correct sequence ends
// it with correct.
//
// Parameters:
//   TIMEOUT_W       width of the inactivity timer
//   TIMEOUT_CYCLES  cycles allowed between accepted presses
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   start        one-cycle pulse: playback finished, begin checking
//   difficulty   sequence length for this round, sampled on start
//   key          active-low tile buttons, key[i] selects tile i
//   seq_tile     sequence-store read data for seq_index (one cycle latency)
//   seq_index    registered read address into the sequence store
//   press_valid  one-cycle pulse when a press is accepted
//   press_tile   tile of the last accepted press
//   correct      one-cycle pulse: whole sequence entered correctly
//   wrong        one-cycle pulse: mismatch or timeout
//   timeout      one-cycle pulse with wrong when the timer caused the failure
//   busy         high whenever a round is in progress
module player_input_checker
    import game_pkg::*;
#(
    parameter int unsigned TIMEOUT_W      = 24,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        difficulty,
    input  logic [3:0]        key,
    input  logic [TILE_W-1:0] seq_tile,
    output logic [5:0]        seq_index,
    output logic              press_valid,
    output logic [TILE_W-1:0] press_tile,
    output logic              correct,
    output logic              wrong,
    output logic              timeout,
    output logic              busy
);

    localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [4:0]          len_q, len_d;
    logic [5:0]          seq_index_q, seq_index_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [TILE_W-1:0]   press_tile_q, press_tile_d;
    logic                press_valid_q, press_valid_d;
    logic                cause_timeout_q, cause_timeout_d;

    logic [3:0]          key_sync;
    logic [3:0]          key_fall;
    logic [5:0]          seq_index_inc;

    // Edges are only reported in StWaitPress, so presses made during
    // compare, release or idle are never queued up.
    key_edge_detect u_key_edge_detect (
        .clock_i    (clock),
        .reset_i    (reset),
        .enable_i   (state_q == StWaitPress),
        .key_i      (key),
        .key_sync_o (key_sync),
        .key_fall_o (key_fall)
    );

    assign seq_index_inc = seq_index_q + 6'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            len_q           <= '0;
            seq_index_q     <= '0;
            timer_q         <= '0;
            press_tile_q    <= '0;
            press_valid_q   <= 1'b0;
            cause_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            seq_index_q     <= seq_index_d;
            timer_q         <= timer_d;
            press_tile_q    <= press_tile_d;
            press_valid_q   <= press_valid_d;
            cause_timeout_q <= cause_timeout_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        seq_index_d     = seq_index_q;
        timer_d         = timer_q;
        press_tile_d    = press_tile_q;
        press_valid_d   = 1'b0;
        cause_timeout_d = cause_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d           = difficulty;
                    seq_index_d     = '0;
                    timer_d         = '0;
                    cause_timeout_d = 1'b0;
                    // A zero-length round has nothing to enter.
                    state_d         = (difficulty == 5'd0) ? StPass : StWaitPress;
                end
            end

            StWaitPress: begin
                if (key_fall != 4'b0000) begin
                    press_tile_d  = lowest_tile(key_fall);
                    press_valid_d = 1'b1;
                    state_d       = StCompare;
                end else if (timer_q == TimeoutLast) begin
                    cause_timeout_d = 1'b1;
                    state_d         = StFail;
                end else if (timer_q != '1) begin
                    // Saturate rather than wrap if TIMEOUT_CYCLES exceeds the range.
                    timer_d = timer_q + 1'b1;
                end
            end

            StCompare: begin
                state_d = (press_tile_q != seq_tile) ? StFail : StWaitRelease;
            end

            StWaitRelease: begin
                if (key_sync == 4'b1111) begin
                    seq_index_d = seq_index_inc;
                    timer_d     = '0;
                    state_d     = (seq_index_inc == {1'b0, len_q}) ? StPass : StWaitPress;
                end
            end

            StPass: begin
                seq_index_d = '0;
                state_d     = StIdle;
            end

            StFail: begin
                seq_index_d     = '0;
                cause_timeout_d = 1'b0;
                state_d         = StIdle;
            end

            default: begin
                seq_index_d = '0;
                state_d     = StIdle;
            end
        endcase
    end

    always_comb begin
        seq_index   = seq_index_q;
        press_valid = press_valid_q;
        press_tile  = press_tile_q;
        correct     = (state_q == StPass);
        wrong       = (state_q == StFail);
        timeout     = (state_q == StFail) && cause_timeout_q;
        busy        = (state_q != StIdle);
    end

endmodule
